dcache_lookup_port: RTL and testbench

//  Single load-port lookup controller feeding one requester port of the dcache tag-compare/arbiter stage.

---
 rtl/std_cache_pkg.sv | 28 ++
 rtl/dcache_way_word_sel.sv | 32 +++
 rtl/dcache_lookup_port.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_lookup_port.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/std_cache_pkg.sv
// Shared dcache types: line layout, lookup FSM states and word-select geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package std_cache_pkg;

   localparam int DCACHE_INDEX_WIDTH = 12;
   localparam int DCACHE_TAG_WIDTH   = 28;
   localparam int DCACHE_LINE_WIDTH  = 256;
   localparam int DCACHE_BYTE_OFFSET = $clog2(DCACHE_LINE_WIDTH / 8);
   // Number of bits that pick one 64-bit word out of a line.
   localparam int DCACHE_WORD_SEL_W  = DCACHE_BYTE_OFFSET - 3;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
      logic                         valid;
      logic [DCACHE_LINE_WIDTH-1:0] data;
   } cache_line_t;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      REQ         = 3'd1,
      CMP         = 3'd2,
      MISS_REQ    = 3'd3,
      MISS_WAIT   = 3'd4,
      KILLED_WAIT = 3'd5
   } lookup_state_e;

endpackage

// File: rtl/dcache_way_word_sel.sv
// Picks the 64-bit word of the hitting way; lowest set way wins if several hit.
// Latency: combinational.
// Backpressure: none.
module dcache_way_word_sel
   import std_cache_pkg::*;
#(
   parameter int  WAYS     = 8,
   parameter type l_data_t = std_cache_pkg::cache_line_t
) (
   input  logic [WAYS-1:0]              hit_way,
   input  l_data_t [WAYS-1:0]           lines,
   input  logic [DCACHE_WORD_SEL_W-1:0] word_sel,
   output logic [63:0]                  word,
   output logic                         hit
);

   // Tag and valid fields are already consumed by the tag-compare stage.
   logic unused_lines;
   assign unused_lines = ^lines;

   // Scan from the top way down so the lowest set way is the last assignment.
   always_comb begin
      word = '0;
      hit  = |hit_way;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_way[w]) begin
            word = lines[w].data[{word_sel, 6'b0} +: 64];
         end
      end
   end

endmodule

// File: rtl/dcache_lookup_port.sv
// Single load-port lookup controller: request -> tag compare -> hit response or miss/refill/replay.
// Latency: 2 cycles acceptance-to-response on a hit with immediate grant; miss adds refill + replay.
// Backpressure: one request in flight; req_ready_o only in IDLE. Optional perf counters: DCACHE_LOOKUP_PERF_EN.
module dcache_lookup_port
   import std_cache_pkg::*;
#(
   parameter int  DCACHE_SET_ASSOC = 8,
   parameter int  MAX_REPLAY       = 2,
   parameter type l_data_t         = std_cache_pkg::cache_line_t
) (
   input  logic                                         clk_i,
   input  logic                                         rst_ni,
   input  logic                                         req_valid_i,
   output logic                                         req_ready_o,
   input  logic [DCACHE_INDEX_WIDTH-1:0]                req_index_i,
   input  logic [DCACHE_TAG_WIDTH-1:0]                  req_tag_i,
   input  logic                                         kill_i,
   output logic                                         rsp_valid_o,
   output logic [63:0]                                  rsp_data_o,
   output logic                                         rsp_err_o,
   output logic                                         miss_req_o,
   output logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] miss_addr_o,
   input  logic                                         miss_gnt_i,
   input  logic                                         miss_done_i,
   output logic [DCACHE_SET_ASSOC-1:0]                  cache_req_o,
   input  logic                                         cache_gnt_i,
   output logic [DCACHE_INDEX_WIDTH-1:0]                cache_addr_o,
   output logic                                         cache_we_o,
   output logic [DCACHE_TAG_WIDTH-1:0]                  cache_tag_o,
   input  l_data_t [DCACHE_SET_ASSOC-1:0]               cache_rdata_i,
   input  logic [DCACHE_SET_ASSOC-1:0]                  cache_hit_way_i,
   output logic [31:0]                                  hit_cnt_o,
   output logic [31:0]                                  miss_cnt_o
);

   localparam int REPLAY_W = ($clog2(MAX_REPLAY + 1) > 2) ? $clog2(MAX_REPLAY + 1) : 2;
   localparam logic [REPLAY_W-1:0] REPLAY_MAX = REPLAY_W'(MAX_REPLAY);
   localparam int BO = DCACHE_BYTE_OFFSET;

   lookup_state_e                 state_q, state_d;
   logic [DCACHE_INDEX_WIDTH-1:0] index_q;
   logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
   logic [REPLAY_W-1:0]           replay_q;

   logic        accept;
   logic        replay_inc;
   logic        cmp_hit;
   logic        cmp_miss;
   logic [63:0] sel_word;
   logic        any_hit;

   dcache_way_word_sel #(
      .WAYS     (DCACHE_SET_ASSOC),
      .l_data_t (l_data_t)
   ) u_word_sel (
      .hit_way  (cache_hit_way_i),
      .lines    (cache_rdata_i),
      .word_sel (index_q[BO-1:3]),
      .word     (sel_word),
      .hit      (any_hit)
   );

   // This port only ever reads the arrays.
   assign cache_we_o  = 1'b0;
   // Refill address is line aligned: offset bits cleared.
   assign miss_addr_o = {tag_q, index_q[DCACHE_INDEX_WIDTH-1:BO], {BO{1'b0}}};

   // State register plus the request context held across replays.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         index_q  <= '0;
         tag_q    <= '0;
         replay_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            index_q  <= req_index_i;
            tag_q    <= req_tag_i;
            replay_q <= '0;
         end else if (replay_inc && (replay_q != REPLAY_MAX)) begin
            replay_q <= replay_q + REPLAY_W'(1);
         end
      end
   end

   // Next-state and Moore/Mealy outputs; every output idles at 0 except ready in IDLE.
   always_comb begin
      state_d      = state_q;
      req_ready_o  = 1'b0;
      rsp_valid_o  = 1'b0;
      rsp_data_o   = '0;
      rsp_err_o    = 1'b0;
      miss_req_o   = 1'b0;
      cache_req_o  = '0;
      cache_addr_o = '0;
      cache_tag_o  = '0;
      accept       = 1'b0;
      replay_inc   = 1'b0;
      cmp_hit      = 1'b0;
      cmp_miss     = 1'b0;
      case (state_q)
         IDLE: begin
            // kill_i has nothing to abort here; a same-cycle request is still taken.
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept  = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            cache_req_o  = '1;
            cache_addr_o = index_q;
            if (kill_i) begin
               state_d = IDLE;
            end else if (cache_gnt_i) begin
               state_d = CMP;
            end
         end
         CMP: begin
            cache_tag_o = tag_q;
            if (kill_i) begin
               state_d = IDLE;
            end else if (any_hit) begin
               cmp_hit     = 1'b1;
               rsp_valid_o = 1'b1;
               rsp_data_o  = sel_word;
               state_d     = IDLE;
            end else begin
               cmp_miss = 1'b1;
               if (replay_q == REPLAY_MAX) begin
                  rsp_valid_o = 1'b1;
                  rsp_err_o   = 1'b1;
                  state_d     = IDLE;
               end else begin
                  state_d = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            miss_req_o = 1'b1;
            // A refill granted in the kill cycle is still in flight and must be drained.
            if (miss_gnt_i) begin
               state_d = kill_i ? KILLED_WAIT : MISS_WAIT;
            end else if (kill_i) begin
               state_d = IDLE;
            end
         end
         MISS_WAIT: begin
            if (miss_done_i) begin
               if (kill_i) begin
                  state_d = IDLE;
               end else begin
                  replay_inc = 1'b1;
                  state_d    = REQ;
               end
            end else if (kill_i) begin
               state_d = KILLED_WAIT;
            end
         end
         KILLED_WAIT: begin
            if (miss_done_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef DCACHE_LOOKUP_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating hit/miss counters; kill-suppressed compares are not counted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (cmp_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (cmp_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = cmp_hit ^ cmp_miss;
   assign hit_cnt_o   = '0;
   assign miss_cnt_o  = '0;
`endif

`ifndef SYNTHESIS
   // The tag-compare stage may report at most one hitting way.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
                    (state_q == CMP) |-> $onehot0(cache_hit_way_i));
`endif

endmodule

// File: tb/tb_dcache_lookup_port.sv
// Bench for dcache_lookup_port: scoreboard of expected responses plus cycle-level checks.
// Inputs change at the falling edge; outputs are checked 1 (main) or 3 (monitor) units later.
// Counter expectations follow DCACHE_LOOKUP_PERF_EN.
module tb_dcache_lookup_port;
   import std_cache_pkg::*;

   localparam int WAYS = 8;
   localparam int MAXR = 2;

   logic                                          clk_i = 1'b0;
   logic                                          rst_ni = 1'b0;
   logic                                          req_valid_i;
   logic                                          req_ready_o;
   logic [DCACHE_INDEX_WIDTH-1:0]                 req_index_i;
   logic [DCACHE_TAG_WIDTH-1:0]                   req_tag_i;
   logic                                          kill_i;
   logic                                          rsp_valid_o;
   logic [63:0]                                   rsp_data_o;
   logic                                          rsp_err_o;
   logic                                          miss_req_o;
   logic [DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:0] miss_addr_o;
   logic                                          miss_gnt_i;
   logic                                          miss_done_i;
   logic [WAYS-1:0]                               cache_req_o;
   logic                                          cache_gnt_i;
   logic [DCACHE_INDEX_WIDTH-1:0]                 cache_addr_o;
   logic                                          cache_we_o;
   logic [DCACHE_TAG_WIDTH-1:0]                   cache_tag_o;
   cache_line_t [WAYS-1:0]                        rdata;
   logic [WAYS-1:0]                               hit_way;
   logic [31:0]                                   hit_cnt_o;
   logic [31:0]                                   miss_cnt_o;

   typedef struct {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   int   model_hits = 0;
   int   model_misses = 0;

   dcache_lookup_port #(
      .DCACHE_SET_ASSOC (WAYS),
      .MAX_REPLAY       (MAXR),
      .l_data_t         (cache_line_t)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .req_index_i     (req_index_i),
      .req_tag_i       (req_tag_i),
      .kill_i          (kill_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_data_o      (rsp_data_o),
      .rsp_err_o       (rsp_err_o),
      .miss_req_o      (miss_req_o),
      .miss_addr_o     (miss_addr_o),
      .miss_gnt_i      (miss_gnt_i),
      .miss_done_i     (miss_done_i),
      .cache_req_o     (cache_req_o),
      .cache_gnt_i     (cache_gnt_i),
      .cache_addr_o    (cache_addr_o),
      .cache_we_o      (cache_we_o),
      .cache_tag_o     (cache_tag_o),
      .cache_rdata_i   (rdata),
      .cache_hit_way_i (hit_way),
      .hit_cnt_o       (hit_cnt_o),
      .miss_cnt_o      (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference content: every (way, word) pair holds a distinct value.
   function automatic logic [63:0] line_word(input int w, input int k);
      return {16'hC0DE, 8'(w), 8'(k), 32'h5A5A_0000 + 32'(w * 4 + k)};
   endfunction

   task automatic fill_lines();
      for (int w = 0; w < WAYS; w++) begin
         rdata[w].tag   = '0;
         rdata[w].valid = 1'b1;
         for (int k = 0; k < 4; k++) begin
            rdata[w].data[k*64 +: 64] = line_word(w, k);
         end
      end
   endtask

   // Presents one request for a cycle; returns at the falling edge after acceptance (DUT in REQ).
   task automatic drive_req(input logic [DCACHE_INDEX_WIDTH-1:0] idx,
                            input logic [DCACHE_TAG_WIDTH-1:0] tag);
      @(negedge clk_i);
      req_valid_i = 1'b1;
      req_index_i = idx;
      req_tag_i   = tag;
      #1 check("req_ready", 64'(req_ready_o), 64'd1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   task automatic do_hit(input logic [DCACHE_INDEX_WIDTH-1:0] idx,
                         input logic [DCACHE_TAG_WIDTH-1:0] tag, input int way);
      cache_gnt_i = 1'b1;
      hit_way     = 8'(1) << way;
      exp_q.push_back('{err: 1'b0, data: line_word(way, int'(idx[4:3]))});
      drive_req(idx, tag);
      @(negedge clk_i);
      @(negedge clk_i);
      model_hits++;
   endtask

   // Persistent miss: expects MAXR+1 compare rounds then an error response.
   task automatic run_replay_limit(input logic [DCACHE_INDEX_WIDTH-1:0] idx,
                                   input logic [DCACHE_TAG_WIDTH-1:0] tag);
      int cmp_rounds;
      int seen;
      cmp_rounds  = 0;
      seen        = 0;
      hit_way     = '0;
      cache_gnt_i = 1'b1;
      miss_gnt_i  = 1'b1;
      miss_done_i = 1'b1;
      exp_q.push_back('{err: 1'b1, data: 64'd0});
      drive_req(idx, tag);
      for (int i = 0; i < 40 && seen == 0; i++) begin
         #1;
         if (cache_tag_o == tag) cmp_rounds++;
         if (rsp_valid_o) seen = 1;
         @(negedge clk_i);
      end
      check("replay_rsp_seen", 64'(seen), 64'd1);
      check("replay_cmp_rounds", 64'(cmp_rounds), 64'(MAXR + 1));
      model_misses += cmp_rounds;
      miss_gnt_i  = 1'b0;
      miss_done_i = 1'b0;
   endtask

   // Scoreboard side: every response must match the oldest outstanding expectation.
   always begin
      @(negedge clk_i);
      #3;
      if (rst_ni && rsp_valid_o) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("rsp_data", rsp_data_o, mon_e.data);
            check("rsp_err", 64'(rsp_err_o), 64'(mon_e.err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_hits;
      logic [31:0] exp_misses;
      req_valid_i = 1'b0;
      req_index_i = '0;
      req_tag_i   = '0;
      kill_i      = 1'b0;
      miss_gnt_i  = 1'b0;
      miss_done_i = 1'b0;
      cache_gnt_i = 1'b0;
      hit_way     = '0;
      fill_lines();

      // Reset values while reset is held.
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_ready", 64'(req_ready_o), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_miss_req", 64'(miss_req_o), 64'd0);
      check("rst_miss_addr", 64'(miss_addr_o), 64'd0);
      check("rst_cache_req", 64'(cache_req_o), 64'd0);
      check("rst_cache_we", 64'(cache_we_o), 64'd0);
      check("rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1) Hit with immediate grant; index 0x040 selects word 0 of the line.
      cache_gnt_i = 1'b1;
      hit_way     = 8'b0000_0100;
      rdata[2].data[63:0] = 64'hDEAD_BEEF;
      exp_q.push_back('{err: 1'b0, data: 64'hDEAD_BEEF});
      drive_req(12'h040, 28'h1A);
      #1;
      check("t1_cache_req", 64'(cache_req_o), 64'hFF);
      check("t1_cache_addr", 64'(cache_addr_o), 64'h040);
      check("t1_cache_we", 64'(cache_we_o), 64'd0);
      @(negedge clk_i);
      #1;
      check("t1_rsp_cycle2", 64'(rsp_valid_o), 64'd1);
      check("t1_cache_tag", 64'(cache_tag_o), 64'h1A);
      @(negedge clk_i);
      #1;
      check("t1_rsp_one_pulse", 64'(rsp_valid_o), 64'd0);
      check("t1_ready_again", 64'(req_ready_o), 64'd1);
      fill_lines();

      // 2) Grant withheld for 3 cycles; request must stay stable. Index 0x088 -> word 1.
      cache_gnt_i = 1'b0;
      hit_way     = 8'b0010_0000;
      exp_q.push_back('{err: 1'b0, data: line_word(5, 1)});
      drive_req(12'h088, 28'h2B);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t2_stall_req", 64'(cache_req_o), 64'hFF);
         check("t2_stall_addr", 64'(cache_addr_o), 64'h088);
         check("t2_stall_no_rsp", 64'(rsp_valid_o), 64'd0);
         @(negedge clk_i);
      end
      cache_gnt_i = 1'b1;
      @(negedge clk_i);
      cache_gnt_i = 1'b0;
      #1 check("t2_rsp_after_gnt", 64'(rsp_valid_o), 64'd1);
      @(negedge clk_i);
      cache_gnt_i = 1'b1;

      // 3) Miss, refill, replay, then hit in way 6. Index 0x05C -> line 0x040, word 3.
      hit_way = '0;
      exp_q.push_back('{err: 1'b0, data: line_word(6, 3)});
      drive_req(12'h05C, 28'h1A);
      @(negedge clk_i);
      #1 check("t3_miss_no_rsp", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      #1;
      check("t3_miss_req", 64'(miss_req_o), 64'd1);
      check("t3_miss_addr", 64'(miss_addr_o), {24'd0, 28'h1A, 12'h040});
      @(negedge clk_i);
      miss_gnt_i = 1'b1;
      #1 check("t3_miss_req_held", 64'(miss_req_o), 64'd1);
      @(negedge clk_i);
      miss_gnt_i = 1'b0;
      #1 check("t3_miss_req_dropped", 64'(miss_req_o), 64'd0);
      repeat (3) @(negedge clk_i);
      @(negedge clk_i);
      miss_done_i = 1'b1;
      hit_way     = 8'b0100_0000;
      @(negedge clk_i);
      miss_done_i = 1'b0;
      #1 check("t3_replay_req", 64'(cache_req_o), 64'hFF);
      @(negedge clk_i);
      #1 check("t3_replay_rsp", 64'(rsp_valid_o), 64'd1);
      @(negedge clk_i);
      #1 check("t3_single_rsp", 64'(rsp_valid_o), 64'd0);

      // 4) Persistent miss runs into the replay limit.
      run_replay_limit(12'h0A0, 28'h77);

      // 5) Kill while waiting for the refill: drain it, no replay, no response.
      hit_way    = '0;
      miss_gnt_i = 1'b1;
      drive_req(12'h100, 28'h33);
      @(negedge clk_i);
      @(negedge clk_i);
      #1 check("t5_miss_req", 64'(miss_req_o), 64'd1);
      @(negedge clk_i);
      kill_i = 1'b1;
      @(negedge clk_i);
      kill_i     = 1'b0;
      miss_gnt_i = 1'b0;
      #1;
      check("t5_killed_not_ready", 64'(req_ready_o), 64'd0);
      check("t5_no_miss_req", 64'(miss_req_o), 64'd0);
      repeat (2) @(negedge clk_i);
      @(negedge clk_i);
      miss_done_i = 1'b1;
      #1 check("t5_ready_wait_done", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      miss_done_i = 1'b0;
      #1;
      check("t5_ready_after_done", 64'(req_ready_o), 64'd1);
      check("t5_no_replay", 64'(cache_req_o), 64'd0);

      // Kill in the compare cycle suppresses a hit response.
      hit_way     = 8'b0000_0001;
      cache_gnt_i = 1'b1;
      drive_req(12'h020, 28'h44);
      @(negedge clk_i);
      kill_i = 1'b1;
      #1 check("kill_cmp_no_rsp", 64'(rsp_valid_o), 64'd0);
      @(negedge clk_i);
      kill_i = 1'b0;
      #1 check("kill_cmp_ready", 64'(req_ready_o), 64'd1);

      // 6) Reset asserted during compare: outputs return to reset values at once.
      drive_req(12'h060, 28'h55);
      @(negedge clk_i);
      #1 check("t6_in_cmp", 64'(cache_tag_o), 64'h55);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_rsp", 64'(rsp_valid_o), 64'd0);
      check("t6_rst_ready", 64'(req_ready_o), 64'd1);
      check("t6_rst_tag", 64'(cache_tag_o), 64'd0);
      check("t6_rst_hit_cnt", 64'(hit_cnt_o), 64'd0);
      check("t6_rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Perf: 10 hits, then one persistent-miss request giving 3 compare misses.
      model_hits   = 0;
      model_misses = 0;
      for (int i = 0; i < 10; i++) begin
         do_hit(12'(12'h200 + i * 8), 28'(28'h60 + i), i % WAYS);
      end
      run_replay_limit(12'h3E0, 28'h99);
`ifdef DCACHE_LOOKUP_PERF_EN
      exp_hits   = 32'(model_hits);
      exp_misses = 32'(model_misses);
`else
      exp_hits   = 32'd0;
      exp_misses = 32'd0;
`endif
      #1;
      check("perf_hits", 64'(hit_cnt_o), 64'(exp_hits));
      check("perf_misses", 64'(miss_cnt_o), 64'(exp_misses));

      repeat (2) @(negedge clk_i);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
